// File: rtl/k2red_pkg.sv
// k2red_pkg: shared FSM state type, width helpers and the shift-subtract multiply by k.
package k2red_pkg;

  typedef enum logic [2:0] {IDLE, RED1, RED2, CORR, DONE} state_t;

  // Wide enough for any round datapath with W up to 126; the round module truncates.
  localparam int unsigned MAX_AW = 256;
  typedef logic signed [MAX_AW-1:0] wide_t;

  function automatic int unsigned c_width(input int unsigned w);
    return w + 2;
  endfunction

  function automatic int unsigned acc_width(input int unsigned w);
    return 2 * w + 2;
  endfunction

  // x * (2^k1 - 2^k2) without a multiplier.
  function automatic wide_t mul_k(input wide_t x, input int unsigned k1, input int unsigned k2);
    return (x << k1) - (x << k2);
  endfunction

endpackage

// File: rtl/k2red_step.sv
// k2red_step: one combinational K2-RED round, y = k*(x mod 2^m) - (x >>> m).
module k2red_step
  import k2red_pkg::*;
#(
  parameter int unsigned AW = 66,
  parameter int unsigned SW = 6
) (
  input  logic signed [AW-1:0] x,
  input  logic [SW-1:0]        k1,
  input  logic [SW-1:0]        k2,
  input  logic [SW-1:0]        m,
  output logic signed [AW-1:0] y
);

  wide_t x_wide;
  wide_t x_low;
  wide_t diff;
  logic  unused_hi;

  always_comb begin
    x_wide = {{(MAX_AW-AW){x[AW-1]}}, x};
    // Low m bits of the two's complement value are the non-negative residue mod 2^m.
    x_low  = x_wide & ~({MAX_AW{1'b1}} << m);
    diff   = mul_k(x_low, 32'(k1), 32'(k2)) - (x_wide >>> m);
  end

  assign y         = diff[AW-1:0];
  assign unused_hi = ^diff[MAX_AW-1:AW];

endmodule

// File: rtl/k2red_iter.sv
// k2red_iter: handshaked K2-RED reducer for q = k*2^m + 1, one shared round datapath.
// Define K2RED_CORR_EN to add the final correction of the result into [0, q).
module k2red_iter
  import k2red_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned SW = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2*W-1:0]               A,
  input  logic [W-1:0]                 Q,
  input  logic [SW-1:0]                k1,
  input  logic [SW-1:0]                k2,
  input  logic [SW-1:0]                m,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [c_width(W)-1:0] C,
  output logic                         err
);

  localparam int unsigned CW = c_width(W);
  localparam int unsigned AW = acc_width(W);

  state_t               state;
  logic [2*W-1:0]       a_reg;
  logic [W-1:0]         q_reg;
  logic [SW-1:0]        k1_reg;
  logic [SW-1:0]        k2_reg;
  logic [SW-1:0]        m_reg;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] step_in;
  logic signed [AW-1:0] step_out;
  logic                 bad_param;

  assign in_ready  = (state == IDLE) && !rst;
  assign bad_param = (k1 <= k2) || (m == '0) || (32'(m) >= W);
  // RED1 reduces the latched operand, RED2 reduces the first-round result.
  assign step_in   = (state == RED1) ? {2'b00, a_reg} : acc;

  k2red_step #(.AW(AW), .SW(SW)) u_step (
    .x  (step_in),
    .k1 (k1_reg),
    .k2 (k2_reg),
    .m  (m_reg),
    .y  (step_out)
  );

`ifdef K2RED_CORR_EN
  logic signed [AW-1:0] q_ext;
  assign q_ext = {{(AW-W){1'b0}}, q_reg};
`else
  logic unused_q;
  assign unused_q = ^q_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      C         <= '0;
      err       <= 1'b0;
      acc       <= '0;
      a_reg     <= '0;
      q_reg     <= '0;
      k1_reg    <= '0;
      k2_reg    <= '0;
      m_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= A;
            q_reg  <= Q;
            k1_reg <= k1;
            k2_reg <= k2;
            m_reg  <= m;
            if (bad_param) begin
              err       <= 1'b1;
              C         <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              err   <= 1'b0;
              state <= RED1;
            end
          end
        end
        RED1: begin
          acc   <= step_out;
          state <= RED2;
        end
        RED2: begin
          acc <= step_out;
`ifdef K2RED_CORR_EN
          state <= CORR;
`else
          C         <= step_out[CW-1:0];
          out_valid <= 1'b1;
          state     <= DONE;
`endif
        end
`ifdef K2RED_CORR_EN
        CORR: begin
          if (acc[AW-1]) begin
            acc <= acc + q_ext;
          end else if (acc >= q_ext) begin
            acc <= acc - q_ext;
          end else begin
            C         <= acc[CW-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_k2red_iter.sv
// tb_k2red_iter: scoreboard bench for k2red_iter; expected results come from modular arithmetic.
// Follows the build of the design: K2RED_CORR_EN selects corrected or raw expectations.
module tb_k2red_iter;
  localparam int W  = 32;
  localparam int SW = 6;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [2*W-1:0]         A;
  logic [W-1:0]           Q;
  logic [SW-1:0]          k1;
  logic [SW-1:0]          k2;
  logic [SW-1:0]          m;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [W+1:0]    C;
  logic                   err;

  k2red_iter #(.W(W), .SW(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .Q(Q), .k1(k1), .k2(k2), .m(m),
    .out_valid(out_valid), .out_ready(out_ready), .C(C), .err(err)
  );

  typedef struct {
    logic [W+1:0] c;
    logic         err;
    int           lat;
    int           stall;
    int           t_acc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input logic [127:0] act,
                       input logic [127:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: residue of k^2*A mod q, plus the raw two-round value for latency / raw builds.
  function automatic exp_t model(input longint unsigned a, input longint unsigned q,
                                 input int ka, input int kb, input int mm);
    exp_t e;
    logic signed [131:0] kv, p, av, qv, c1, fl, c2, r;
    longint unsigned ku, kk, val;
    int n;
    e.stall = 0;
    e.t_acc = 0;
    if (ka <= kb || mm == 0 || mm >= W) begin
      e.err = 1'b1;
      e.c   = '0;
      e.lat = 1;
      return e;
    end
    e.err = 1'b0;
    kv = (132'sd1 <<< ka) - (132'sd1 <<< kb);
    p  = 132'sd1 <<< mm;
    av = $signed({68'd0, a});
    qv = $signed({68'd0, q});
    c1 = kv * (av % p) - (av / p);
    fl = (c1 >= 0) ? (c1 / p) : -((-c1 + p - 1) / p);
    c2 = kv * (c1 - fl * p) - fl;
`ifdef K2RED_CORR_EN
    r = c2;
    n = 0;
    while ((r < 0 || r >= qv) && n < 100) begin
      if (r < 0) r = r + qv;
      else r = r - qv;
      n++;
    end
    e.lat = 4 + n;
    ku  = (64'd1 << ka) - (64'd1 << kb);
    kk  = (ku * ku) % q;
    val = (kk * (a % q)) % q;
    e.c = val[W+1:0];
`else
    r     = c2;
    e.lat = 3;
    e.c   = r[W+1:0];
`endif
    return e;
  endfunction

  task automatic issue(input longint unsigned ta, input longint unsigned tq,
                       input int tk1, input int tk2, input int tm, input int stall);
    exp_t e;
    int   i;
    e = model(ta, tq, tk1, tk2, tm);
    e.stall = stall;
    @(negedge clk);
    A  = ta;
    Q  = tq[W-1:0];
    k1 = tk1[SW-1:0];
    k2 = tk2[SW-1:0];
    m  = tm[SW-1:0];
    in_valid = 1'b1;
    for (i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      check("accept_timeout", 1'b0, 0, 1);
      in_valid = 1'b0;
      return;
    end
    e.t_acc = cyc;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = {$urandom, $urandom};
    Q = $urandom;
  endtask

  // Monitor: pops on each new result, checks value, err, latency and stability while stalled.
  initial begin
    exp_t         e;
    logic [W+1:0] held_c;
    logic         held_err;
    bit           holding;
    int           stall;
    holding   = 1'b0;
    stall     = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        holding   = 1'b0;
        out_ready = 1'b0;
      end else if (out_valid) begin
        check("in_ready_while_busy", in_ready == 1'b0, in_ready, 0);
        if (!holding) begin
          if (sbq.size() == 0) begin
            check("unexpected_out", 1'b0, C, 0);
            out_ready = 1'b1;
          end else begin
            e = sbq.pop_front();
            check("result_c", C === e.c, C, e.c);
            check("result_err", err === e.err, err, e.err);
            check("latency", (cyc - e.t_acc) == e.lat, cyc - e.t_acc, e.lat);
            held_c   = C;
            held_err = err;
            stall    = e.stall;
            holding  = 1'b1;
          end
        end else begin
          check("c_stable", C === held_c, C, held_c);
          check("err_stable", err === held_err, err, held_err);
        end
        if (holding) begin
          if (stall == 0) begin
            out_ready = 1'b1;
            holding   = 1'b0;
          end else begin
            stall--;
            out_ready = 1'b0;
          end
        end
      end else begin
        if (holding) begin
          check("valid_dropped", 1'b0, 0, 1);
          holding = 1'b0;
        end
        out_ready = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

  localparam longint unsigned Q1 = 64'd2147352577;
  localparam longint unsigned A1 = 64'd139801577094305698;

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    A = '0; Q = '0; k1 = '0; k2 = '0; m = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready_low", in_ready == 1'b0, in_ready, 0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", in_ready == 1'b1, in_ready, 1);
    check("reset_out_valid", out_valid == 1'b0, out_valid, 0);
    check("reset_c", C == '0, C, 0);
    check("reset_err", err == 1'b0, err, 0);

    issue(A1, Q1, 14, 0, 17, 0);
    issue(64'd0, Q1, 14, 0, 17, 0);
    issue(Q1, Q1, 14, 0, 17, 1);
    issue(A1, Q1, 0, 14, 17, 0);
    issue(A1, Q1, 14, 0, 0, 0);
    issue(A1, Q1, 14, 0, 32, 0);
    issue(Q1 * Q1 - 1, Q1, 14, 0, 17, 0);

    // Long consumer stall, with a second request already waiting behind it.
    issue(A1, Q1, 14, 0, 17, 10);
    issue(64'd0, Q1, 14, 0, 17, 0);

    // Reset while the job is in its second round.
    issue(A1, Q1, 14, 0, 17, 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid == 1'b0, out_valid, 0);
    check("rst_mid_c", C == '0, C, 0);
    check("rst_mid_in_ready", in_ready == 1'b1, in_ready, 1);
    issue(A1, Q1, 14, 0, 17, 0);

    for (int i = 0; i < 150; i++) begin
      int mm, ka, kb, sel;
      longint unsigned qq, aa;
      mm = $urandom_range(W - 1, W / 2);
      ka = $urandom_range(W - mm, 1);
      kb = $urandom_range(ka - 1, 0);
      qq = (((64'd1 << ka) - (64'd1 << kb)) << mm) + 1;
      sel = $urandom_range(9, 0);
      case (sel)
        0: aa = 64'd0;
        1: aa = qq;
        2: aa = qq * qq - 1;
        default: aa = {$urandom, $urandom} % (qq * qq);
      endcase
      if ($urandom_range(9, 0) == 0) begin
        case ($urandom_range(2, 0))
          0: kb = ka;
          1: mm = 0;
          default: mm = $urandom_range(63, W);
        endcase
      end
      issue(aa, qq, ka, kb, mm, $urandom_range(2, 0));
    end

    for (int i = 0; i < 200 && (sbq.size() != 0 || out_valid); i++) @(negedge clk);
    check("drain", sbq.size() == 0, sbq.size(), 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
